imu_moving_avg: RTL and testbench



---
 rtl/imu_pkg.sv | 16 +
 rtl/imu_sample_ring.sv | 49 ++++
 rtl/imu_moving_avg.sv | 84 ++++++++
 tb/tb_imu_moving_avg.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/imu_pkg.sv
// imu_pkg: constants and helpers shared by the IMU sample-smoothing blocks.
//   IMU_WIDTH      - raw sample width in bits (two's-complement)
//   IMU_LOG2_DEPTH - default log2 of the moving-average window length
//   sum_width()    - width of a signed running sum covering 2^log2_depth
//                    samples of the given width
package imu_pkg;

  localparam int IMU_WIDTH      = 16;
  localparam int IMU_LOG2_DEPTH = 2;

  // Adding 2^L values of W bits grows the magnitude by at most L bits.
  function automatic int sum_width(input int width, input int log2_depth);
    return width + log2_depth;
  endfunction

endpackage

// File: rtl/imu_sample_ring.sv
// imu_sample_ring: N-entry circular sample buffer (N = 2^LOG2_DEPTH).
// It is built from discrete registers rather than RAM so that clear can
// zero every entry in a single cycle.
//   clk     - system clock, rising edge
//   rst     - synchronous active-high reset (all entries and pointer to 0)
//   clear   - synchronous flush, same effect as rst
//   wr_en   - write wr_data into the slot at the write pointer, then advance
//   wr_data - sample to store
//   oldest  - entry at the write pointer, i.e. the sample about to be evicted
//             (0 while the window is still filling)
module imu_sample_ring #(
  parameter int WIDTH      = 16,
  parameter int LOG2_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] oldest
);

  localparam int N = 1 << LOG2_DEPTH;

  logic [WIDTH-1:0]      entry_reg [N];
  logic [LOG2_DEPTH-1:0] wr_ptr_reg;

  // N is a power of two, so the pointer wraps N-1 -> 0 by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_reg <= '0;
    end else if (wr_en) begin
      wr_ptr_reg <= wr_ptr_reg + LOG2_DEPTH'(1);
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst || clear) begin
        entry_reg[gi] <= '0;
      end else if (wr_en && (wr_ptr_reg == LOG2_DEPTH'(gi))) begin
        entry_reg[gi] <= wr_data;
      end
    end
  end

  assign oldest = entry_reg[wr_ptr_reg];

endmodule

// File: rtl/imu_moving_avg.sv
// imu_moving_avg: boxcar moving-average filter for the raw IMU stream.
// Emits the floor of (sum of last N accepted samples) / N one cycle after
// each accepted sample; empty slots count as zero during warm-up.
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset
//   in_valid  - qualifies in_sample for one cycle
//   in_sample - signed raw sample
//   clear     - synchronous flush of all window state (drops a coincident sample)
//   out_valid - one-cycle pulse, out_avg updated
//   out_avg   - signed window mean
//   primed    - high once N samples accepted since last reset/clear
module imu_moving_avg
  import imu_pkg::*;
#(
  parameter int WIDTH      = IMU_WIDTH,
  parameter int LOG2_DEPTH = IMU_LOG2_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_sample,
  input  logic             clear,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_avg,
  output logic             primed
);

  localparam int N     = 1 << LOG2_DEPTH;
  localparam int SUM_W = sum_width(WIDTH, LOG2_DEPTH);
  localparam logic [LOG2_DEPTH:0] FILL_MAX  = (LOG2_DEPTH + 1)'(N);
  localparam logic [LOG2_DEPTH:0] FILL_LAST = (LOG2_DEPTH + 1)'(N - 1);

  logic                    accept;
  logic [WIDTH-1:0]        oldest;
  logic signed [SUM_W-1:0] sample_ext;
  logic signed [SUM_W-1:0] oldest_ext;
  logic signed [SUM_W-1:0] sum_reg;
  logic signed [SUM_W-1:0] sum_next;
  logic [LOG2_DEPTH:0]     fill_reg;

  // clear wins over in_valid: a coincident sample is dropped.
  assign accept = in_valid && !clear;

  imu_sample_ring #(
    .WIDTH      (WIDTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .wr_en   (accept),
    .wr_data (in_sample),
    .oldest  (oldest)
  );

  assign sample_ext = {{LOG2_DEPTH{in_sample[WIDTH-1]}}, in_sample};
  assign oldest_ext = {{LOG2_DEPTH{oldest[WIDTH-1]}}, oldest};
  assign sum_next   = sum_reg + sample_ext - oldest_ext;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum_reg   <= '0;
      fill_reg  <= '0;
      out_avg   <= '0;
      out_valid <= 1'b0;
      primed    <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        sum_reg <= sum_next;
        // Dropping the low LOG2_DEPTH bits of the signed sum is the arithmetic
        // right shift (floor toward -inf); the mean always fits in WIDTH bits.
        out_avg <= sum_next[LOG2_DEPTH +: WIDTH];
        if (fill_reg != FILL_MAX) begin
          fill_reg <= fill_reg + (LOG2_DEPTH + 1)'(1);
        end
        if (fill_reg == FILL_LAST) begin
          primed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imu_moving_avg.sv
module tb_imu_moving_avg;

  localparam int W  = 16;
  localparam int L2 = 2;
  localparam int N  = 1 << L2;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic signed [W-1:0] in_sample;
  logic                clear;
  logic                out_valid;
  logic signed [W-1:0] out_avg;
  logic                primed;

  int total = 0;
  int bad   = 0;

  // reference model state
  int                  win[$];
  int                  accepted;
  logic                exp_valid;
  logic signed [W-1:0] exp_avg;
  logic                exp_primed;

  imu_moving_avg #(.WIDTH(W), .LOG2_DEPTH(L2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sample (in_sample),
    .clear     (clear),
    .out_valid (out_valid),
    .out_avg   (out_avg),
    .primed    (primed)
  );

  always #5 clk = ~clk;

  task automatic model_flush();
    win = {};
    for (int i = 0; i < N; i++) win.push_back(0);
    accepted   = 0;
    exp_valid  = 1'b0;
    exp_avg    = '0;
    exp_primed = 1'b0;
  endtask

  // Mean of the last N accepted samples (zeros for empty slots), floored.
  task automatic model_accept(input int s);
    int sum;
    int q;
    win.push_back(s);
    void'(win.pop_front());
    sum = 0;
    foreach (win[i]) sum += win[i];
    q = sum / N;
    if (sum < 0 && (sum % N) != 0) q = q - 1;
    exp_avg   = q[W-1:0];
    exp_valid = 1'b1;
    accepted++;
    exp_primed = (accepted >= N);
  endtask

  // Apply one cycle of inputs, advance the model, leave outputs ready to sample.
  task automatic cycle(input logic r, input logic c, input logic v, input int s);
    rst       = r;
    clear     = c;
    in_valid  = v;
    in_sample = s[W-1:0];
    @(posedge clk);
    #1;
    if (r || c) model_flush();
    else if (v) model_accept(int'(in_sample));
    else exp_valid = 1'b0;
    if (v && !r && !c) $display("txn sample=%0d avg=%0d primed=%0b", in_sample, out_avg, primed);
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 0);
      total++;
      if ({out_valid, primed, out_avg} !== {1'b0, 1'b0, 16'sd0}) begin
        bad++;
        $display("FAIL reset got valid=%0b primed=%0b avg=%0d need 0/0/0", out_valid, primed, out_avg);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 0);
      total++;
      if ({out_valid, primed, out_avg} !== {1'b0, 1'b0, 16'sd0}) begin
        bad++;
        $display("FAIL reset_idle got valid=%0b primed=%0b avg=%0d need 0/0/0", out_valid, primed, out_avg);
      end
    end
  endtask

  task automatic test_warmup();
    int samp[4];
    int want[4];
    samp = '{4, 8, 12, 16};
    want = '{1, 3, 6, 10};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b1, samp[i]);
      total++;
      if ({out_valid, primed, out_avg} !== {exp_valid, exp_primed, exp_avg} ||
          int'(out_avg) != want[i] || primed !== (i == 3)) begin
        bad++;
        $display("FAIL warmup[%0d] got valid=%0b primed=%0b avg=%0d need 1/%0b/%0d",
                 i, out_valid, primed, out_avg, (i == 3), want[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int samp[2];
    int want[2];
    samp = '{20, 24};
    want = '{14, 18};
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 1'b1, samp[i]);
      total++;
      if ({out_valid, primed, out_avg} !== {exp_valid, exp_primed, exp_avg} || int'(out_avg) != want[i]) begin
        bad++;
        $display("FAIL wrap[%0d] got valid=%0b primed=%0b avg=%0d need 1/1/%0d",
                 i, out_valid, primed, out_avg, want[i]);
      end
    end
  endtask

  task automatic test_signed();
    int seq[$];
    // three sub-runs, each preceded by a clear; 99999 marks a clear
    seq = {99999, -1, -4, -4, -4,
           99999, 32767, 32767, 32767, 32767,
           99999, -32768, -32768, -32768, -32768};
    foreach (seq[i]) begin
      if (seq[i] == 99999) cycle(1'b0, 1'b1, 1'b0, 0);
      else cycle(1'b0, 1'b0, 1'b1, seq[i]);
      total++;
      if ({out_valid, primed, out_avg} !== {exp_valid, exp_primed, exp_avg}) begin
        bad++;
        $display("FAIL signed[%0d] got valid=%0b primed=%0b avg=%0d need %0b/%0b/%0d",
                 i, out_valid, primed, out_avg, exp_valid, exp_primed, exp_avg);
      end
    end
    total++;
    if (out_avg !== -16'sd32768 || primed !== 1'b1) begin
      bad++;
      $display("FAIL signed_min got avg=%0d primed=%0b need -32768/1", out_avg, primed);
    end
  endtask

  task automatic test_sparse();
    cycle(1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, (i % 5) == 0, 8);
      total++;
      if ({out_valid, primed, out_avg} !== {exp_valid, exp_primed, exp_avg}) begin
        bad++;
        $display("FAIL sparse[%0d] got valid=%0b primed=%0b avg=%0d need %0b/%0b/%0d",
                 i, out_valid, primed, out_avg, exp_valid, exp_primed, exp_avg);
      end
    end
    total++;
    if (out_avg !== 16'sd8) begin
      bad++;
      $display("FAIL sparse_final got avg=%0d need 8", out_avg);
    end
  endtask

  task automatic test_collision();
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 10);
      if (k == 0) cycle(1'b0, 1'b1, 1'b1, 100);
      else cycle(1'b1, 1'b0, 1'b1, 100);
      total++;
      if ({out_valid, primed, out_avg} !== {1'b0, 1'b0, 16'sd0}) begin
        bad++;
        $display("FAIL collision%0d got valid=%0b primed=%0b avg=%0d need 0/0/0",
                 k, out_valid, primed, out_avg);
      end
      cycle(1'b0, 1'b0, 1'b1, 8);
      total++;
      if ({out_valid, primed, out_avg} !== {1'b1, 1'b0, 16'sd2}) begin
        bad++;
        $display("FAIL collision%0d_after got valid=%0b primed=%0b avg=%0d need 1/0/2",
                 k, out_valid, primed, out_avg);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic c;
      logic v;
      int   s;
      c = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      s = int'($signed(16'($urandom)));
      cycle(1'b0, c, v, s);
      total++;
      if ({out_valid, primed, out_avg} !== {exp_valid, exp_primed, exp_avg}) begin
        bad++;
        $display("FAIL random[%0d] got valid=%0b primed=%0b avg=%0d need %0b/%0b/%0d",
                 i, out_valid, primed, out_avg, exp_valid, exp_primed, exp_avg);
      end
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_sample = '0;
    model_flush();
    test_reset();
    test_warmup();
    test_wrap();
    test_signed();
    test_sparse();
    test_collision();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
